// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory arbiter that sits between the
// multicycle CPU's instruction-fetch port, its load/store port and the
// single-port data Memory.
//
// Contents
//   arb_state_t : arbiter sequencer states (IDLE, ACCESS, DONE)
//   req_id_t    : identity of a requester (REQ_IF = fetch, REQ_D = data)
//   CNT_W       : width of the strobe-hold down-counter (MEM_LATENCY <= 15)
//
// Optional build macro used by the files that import this package:
//   MEM_ARB_RR_EN : round-robin arbitration instead of fixed data priority.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  // Sequencer states. IDLE waits for a request, ACCESS holds the Memory
  // strobe, DONE delivers the one-cycle acknowledge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Requester identity. REQ_IF is deliberately the all-zero encoding so that
  // the cleared last-grant register means "fetch was granted last".
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  // Counter width for the strobe-hold down-counter; holds MEM_LATENCY-1.
  localparam int CNT_W = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
// Combinational arbitration decision for mem_arbiter. Looks at the two
// request lines (and, in round-robin builds, at who was granted last) and
// names the requester that should be served next.
//
// Ports
//   i_if_req       in   1  fetch request
//   i_d_req        in   1  data (load/store) request
//   i_last_grant   in   1  requester granted last (req_id_t encoding)
//   o_grant        out  1  requester to serve (req_id_t encoding)
//   o_grant_valid  out  1  at least one request is pending
//
// Build macro
//   MEM_ARB_RR_EN defined   : on a conflict grant the requester that was NOT
//                             granted last.
//   MEM_ARB_RR_EN undefined : fixed priority, data wins over fetch; the
//                             last-grant input is ignored.
// ----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_grant_valid
);

`ifdef MEM_ARB_RR_EN

  // Round-robin: a lone requester always wins; on a conflict the side that
  // was not served last goes first, so neither port can starve the other.
  always_comb begin
    o_grant_valid = i_if_req | i_d_req;
    o_grant       = REQ_D;
    if (i_if_req && i_d_req) begin
      o_grant = (i_last_grant == REQ_D) ? REQ_IF : REQ_D;
    end else if (i_if_req) begin
      o_grant = REQ_IF;
    end
  end

`else

  // Fixed priority: a pending data access always goes ahead of a fetch,
  // which lets the load/store in flight finish before the next instruction.
  logic w_unused_last_grant;

  assign w_unused_last_grant = i_last_grant;

  always_comb begin
    o_grant_valid = i_if_req | i_d_req;
    o_grant       = i_d_req ? REQ_D : REQ_IF;
  end

`endif

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port data Memory between the CPU instruction-fetch port
// and the load/store port. The arbiter owns Memory's address, write data,
// memRead and memWrite pins and sequences every access as a strobe pulse, so
// each access presents Memory with a fresh rising edge. Each requester gets a
// one-cycle acknowledge with its read data.
//
// Parameters
//   ADDR_W       address width on all ports
//   DATA_W       data width on all ports
//   MEM_LATENCY  cycles the strobe is held before Memory read data is
//                sampled (legal range 1..15)
//
// Ports
//   i_clk        in   1       clock, rising edge
//   i_rst_n      in   1       asynchronous active-low reset
//   i_if_req     in   1       fetch request, held with i_if_addr until ack
//   i_if_addr    in   ADDR_W  fetch address
//   o_if_ack     out  1       one-cycle pulse, o_if_rdata valid
//   o_if_rdata   out  DATA_W  fetched word (holds between acks)
//   i_d_req      in   1       data request, held with operands until ack
//   i_d_we       in   1       1 = store, 0 = load
//   i_d_addr     in   ADDR_W  data address
//   i_d_wdata    in   DATA_W  store data
//   o_d_ack      out  1       one-cycle pulse, o_d_rdata valid
//   o_d_rdata    out  DATA_W  load data, 0 after a store
//   o_mem_addr   out  ADDR_W  Memory address (0 outside ACCESS)
//   o_mem_wdata  out  DATA_W  Memory write data (0 outside ACCESS)
//   o_mem_read   out  1       Memory memRead strobe
//   o_mem_write  out  1       Memory memWrite strobe
//   i_mem_rdata  in   DATA_W  Memory read data
//   o_busy       out  1       arbiter is not IDLE
//
// Build macro
//   MEM_ARB_RR_EN : round-robin arbitration (see mem_arb_pick). When it is
//                   undefined the last-grant register is not built.
//
// Timing: a request seen in IDLE in cycle t is acknowledged in cycle
// t+MEM_LATENCY+1; a requester can be served at most every MEM_LATENCY+2
// cycles.
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  // The counter is loaded with MEM_LATENCY-1 at grant and the strobe ends
  // when it reaches zero, giving exactly MEM_LATENCY strobe cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t       r_state;
  req_id_t          r_grant;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;

  logic             w_last_grant;
  logic             w_grant;
  logic             w_grant_valid;
  req_id_t          w_grant_id;
  logic             w_grant_we;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [DATA_W-1:0] w_grant_wdata;

`ifdef MEM_ARB_RR_EN

  // Remembers which side was served most recently so the picker can favour
  // the other one on the next conflict. Clears to "fetch", which means the
  // very first conflict after reset is given to the data port.
  req_id_t r_last_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= REQ_IF;
    end else if (r_state == IDLE && w_grant_valid) begin
      r_last_grant <= w_grant_id;
    end
  end

  assign w_last_grant = r_last_grant;

`else

  assign w_last_grant = REQ_IF;

`endif

  mem_arb_pick u_pick (
    .i_if_req      (i_if_req),
    .i_d_req       (i_d_req),
    .i_last_grant  (w_last_grant),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // Operands of the winning requester. Fetches never write, so their write
  // data is forced to zero rather than leaking the data port's store value.
  assign w_grant_id    = req_id_t'(w_grant);
  assign w_grant_we    = (w_grant_id == REQ_D) && i_d_we;
  assign w_grant_addr  = (w_grant_id == REQ_D) ? i_d_addr : i_if_addr;
  assign w_grant_wdata = (w_grant_id == REQ_D) ? i_d_wdata : '0;

  // Busy is simply "not idle"; it comes straight from the state register.
  assign o_busy = (r_state != IDLE);

  // Main sequencer. All Memory pins and acknowledges are registered here.
  // The granted operands are latched directly into the Memory address and
  // write-data registers, which therefore double as the operand latches and
  // are cleared again when the strobe ends. The acks default to zero each
  // cycle so they can only ever be one-cycle pulses. An asynchronous reset
  // drops the strobes immediately and discards any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_grant     <= REQ_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      o_if_ack    <= 1'b0;
      o_if_rdata  <= '0;
      o_d_ack     <= 1'b0;
      o_d_rdata   <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
    end else begin
      o_if_ack <= 1'b0;
      o_d_ack  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_grant     <= w_grant_id;
            r_we        <= w_grant_we;
            r_cnt       <= CNT_LOAD;
            o_mem_addr  <= w_grant_addr;
            o_mem_wdata <= w_grant_wdata;
            o_mem_read  <= !w_grant_we;
            o_mem_write <= w_grant_we;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            // Last strobe cycle: capture the word and hand it to the
            // granted side; a store reports zero as its load data.
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            if (r_grant == REQ_IF) begin
              o_if_rdata <= i_mem_rdata;
              o_if_ack   <= 1'b1;
            end else begin
              o_d_rdata <= r_we ? '0 : i_mem_rdata;
              o_d_ack   <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with MEM_LATENCY = 3. A small behavioural
// Memory answers reads combinationally and commits writes on the rising clock
// edge while memWrite is high. Words never written read back as
// 0x1000_0000 + word index. Honours MEM_ARB_RR_EN for the arbitration order.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        rstN;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifAck;
  logic [31:0] ifRdata;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic        dAck;
  logic [31:0] dRdata;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memRdata;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int ifAckCount  = 0;
  int dAckCount   = 0;

  // Behavioural Memory: 64 words, word addressed by memAddr[7:2].
  logic [31:0] mem [64];
  bit          written [64];
  logic [5:0]  memIdx;
  logic        unusedBits;

  assign memIdx     = memAddr[7:2];
  assign unusedBits = ^{memAddr[31:8], memAddr[1:0]};
  assign memRdata   = memRead ? (written[memIdx] ? mem[memIdx] : {26'h0400000, memIdx}) : 32'h0;

  always @(posedge clock) begin
    if (memWrite) begin
      mem[memIdx]     <= memWdata;
      written[memIdx] <= 1'b1;
    end
  end

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Ack pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (ifAck) ifAckCount <= ifAckCount + 1;
    if (dAck)  dAckCount  <= dAckCount + 1;
  end

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_LATENCY (LAT)
  ) dut (
    .i_clk       (clock),
    .i_rst_n     (rstN),
    .i_if_req    (ifReq),
    .i_if_addr   (ifAddr),
    .o_if_ack    (ifAck),
    .o_if_rdata  (ifRdata),
    .i_d_req     (dReq),
    .i_d_we      (dWe),
    .i_d_addr    (dAddr),
    .i_d_wdata   (dWdata),
    .o_d_ack     (dAck),
    .o_d_rdata   (dRdata),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_mem_read  (memRead),
    .o_mem_write (memWrite),
    .i_mem_rdata (memRdata),
    .o_busy      (busy)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives all request inputs at once.
  task automatic applyStimulus(input logic ifR, input logic [31:0] ifA, input logic dR,
                               input logic we, input logic [31:0] dA, input logic [31:0] dW);
    ifReq  = ifR;
    ifAddr = ifA;
    dReq   = dR;
    dWe    = we;
    dAddr  = dA;
    dWdata = dW;
  endtask

  // Waits (bounded) for the chosen ack. lat = number of mid-cycle samples
  // before the ack sample; strobe cycles are counted along the way.
  task automatic waitAck(input bit isData, output int lat, output int rdCyc, output int wrCyc);
    bit seen;
    seen  = 1'b0;
    lat   = 0;
    rdCyc = 0;
    wrCyc = 0;
    while (!seen && lat <= 40) begin
      @(negedge clock);
      if (isData ? dAck : ifAck) seen = 1'b1;
      else begin
        rdCyc += int'(memRead);
        wrCyc += int'(memWrite);
        lat++;
      end
    end
    if (!seen) checkOutput(isData ? "d_ack timeout" : "if_ack timeout", 32'd0, 32'd1);
  endtask

  // Two requesters raised together; firstIsData names the expected winner.
  task automatic conflict(input bit firstIsData, input string tag);
    int lat, rd, wr;
    @(posedge clock); #1;
    applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'h10, 32'h0);
    waitAck(firstIsData, lat, rd, wr);
    checkOutput({tag, " first lat"}, lat, LAT + 1);
    checkOutput({tag, " first other ack"}, firstIsData ? ifAck : dAck, 1'b0);
    checkOutput({tag, " first rdata"}, firstIsData ? dRdata : ifRdata,
                firstIsData ? 32'hDEADBEEF : 32'h1000_0001);
    @(posedge clock); #1;
    if (firstIsData) dReq = 1'b0; else ifReq = 1'b0;
    waitAck(!firstIsData, lat, rd, wr);
    checkOutput({tag, " second lat"}, lat, LAT + 1);
    checkOutput({tag, " second other ack"}, firstIsData ? dAck : ifAck, 1'b0);
    checkOutput({tag, " second rdata"}, firstIsData ? ifRdata : dRdata,
                firstIsData ? 32'h1000_0001 : 32'hDEADBEEF);
    @(posedge clock); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Single data access from a quiet arbiter.
  task automatic dataAccess(input logic we, input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] expRdata, input string tag);
    int lat, rd, wr;
    @(posedge clock); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, we, a, w);
    waitAck(1'b1, lat, rd, wr);
    checkOutput({tag, " lat"}, lat, LAT + 1);
    checkOutput({tag, " read cycles"}, rd, we ? 0 : LAT);
    checkOutput({tag, " write cycles"}, wr, we ? LAT : 0);
    checkOutput({tag, " d_rdata"}, dRdata, expRdata);
    checkOutput({tag, " if_ack quiet"}, ifAck, 1'b0);
    checkOutput({tag, " strobes low at ack"}, {memRead, memWrite}, 2'b00);
    @(posedge clock); #1;
    dReq = 1'b0;
  endtask

  initial begin
    int lat, rd, wr, base;
    int ackCycle [3];

    // Reset state.
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset acks", {ifAck, dAck}, 2'b00);
    checkOutput("reset strobes", {memRead, memWrite}, 2'b00);
    checkOutput("reset mem_addr", memAddr, 32'h0);
    checkOutput("reset mem_wdata", memWdata, 32'h0);
    checkOutput("reset if_rdata", ifRdata, 32'h0);
    checkOutput("reset d_rdata", dRdata, 32'h0);
    rstN = 1'b1;

    // Reset in the middle of a store: strobe drops at once, no ack, no write.
    @(posedge clock); #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clock);
    @(negedge clock);
    checkOutput("midreset write high", memWrite, 1'b1);
    checkOutput("midreset addr", memAddr, 32'h10);
    #1 rstN = 1'b0;
    #1;
    checkOutput("midreset write dropped", memWrite, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    dReq = 1'b0;
    repeat (3) @(negedge clock);
    rstN = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("midreset no d_ack", dAckCount, 0);
    checkOutput("midreset mem unchanged", written[4] ? mem[4] : 32'h1000_0004, 32'h1000_0004);

    // Load, store, then load back the stored word.
    dataAccess(1'b0, 32'h20, 32'h0, 32'h1000_0008, "load 0x20");
    dataAccess(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "store 0x10");
    checkOutput("store committed", written[4] ? mem[4] : 32'h0, 32'hDEADBEEF);
    dataAccess(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "load 0x10");

    // Early drop: fetch request held one cycle; address changes afterwards.
    base = ifAckCount;
    @(posedge clock); #1;
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    ifReq  = 1'b0;
    ifAddr = 32'h0C;
    waitAck(1'b0, lat, rd, wr);
    checkOutput("early drop lat", lat, LAT);
    checkOutput("early drop rdata", ifRdata, 32'h1000_0002);
    repeat (8) @(negedge clock);
    checkOutput("early drop one ack", ifAckCount - base, 1);
    checkOutput("early drop idle", busy, 1'b0);

    // First conflict after a fetch grant: data goes first in both modes.
    conflict(1'b1, "conflict A");

    // After a lone load, round-robin favours fetch; fixed still picks data.
    dataAccess(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "load before B");
`ifdef MEM_ARB_RR_EN
    conflict(1'b0, "conflict B");
`else
    conflict(1'b1, "conflict B");
`endif

    // Back-to-back fetches at 0x0, 0x4, 0x8 with the request held throughout.
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      waitAck(1'b0, lat, rd, wr);
      ackCycle[i] = cycleCount;
      checkOutput($sformatf("b2b %0d lat", i), lat, LAT + 1);
      checkOutput($sformatf("b2b %0d rdata", i), ifRdata, 32'h1000_0000 + 32'(i));
      checkOutput($sformatf("b2b %0d read low at ack", i), memRead, 1'b0);
      @(posedge clock); #1;
    end
    ifReq = 1'b0;
    checkOutput("b2b spacing 0-1", ackCycle[1] - ackCycle[0], LAT + 2);
    checkOutput("b2b spacing 1-2", ackCycle[2] - ackCycle[1], LAT + 2);
    repeat (4) @(negedge clock);
    checkOutput("final idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_mem_arbiter
